// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adder_seq_ctrl
//  Purpose  : Performs W-bit additions (W = 4*NIBBLES) on one external 4-bit
//             combinational adder. Operands are fed one nibble per cycle,
//             least-significant first, with the carry chained through a
//             register.
//  Options  : `define ADDSEQ_SUB_EN to enable subtraction (sub=1 gives
//             op_a - op_b). Without it, sub is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    input  logic                   sub,
    input  logic                   flush,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_ci,
    input  logic [3:0]             add_s,
    input  logic                   add_co,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic [W-1:0]    b_in;
    logic            carry_in;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;

    // Operand conditioning at accept: subtraction is A + ~B + 1 on the same adder
`ifdef ADDSEQ_SUB_EN
    always_comb begin
        b_in     = op_b;
        carry_in = cin;
        if (sub) begin
            b_in     = ~op_b;
            carry_in = 1'b1;
        end
    end
`else
    logic unused_sub;
    assign unused_sub = sub;
    always_comb begin
        b_in     = op_b;
        carry_in = cin;
    end
`endif

    // Current nibble of each operand, selected by the nibble index
    assign a_sh = a_q >> {k_q, 2'b00};
    assign b_sh = b_q >> {k_q, 2'b00};

    // State, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and adder drive; flush overrides everything and freezes data
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_ci  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = b_in;
                    carry_d = carry_in;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_sh[3:0];
                add_b   = b_sh[3:0];
                add_ci  = carry_q;
                sum_d[{k_q, 2'b00} +: 4] = add_s;
                carry_d = add_co;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cout_d  = add_co;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            k_d     = '0;
            a_d     = a_q;
            b_d     = b_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            cout_d  = cout_q;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_seq_ctrl
//  Purpose  : Self-checking bench for adder_seq_ctrl with a behavioural
//             4-bit adder and a result scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic           clk;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           cin;
    logic           sub;
    logic           flush;
    logic [3:0]     add_a;
    logic [3:0]     add_b;
    logic           add_ci;
    logic [3:0]     add_s;
    logic           add_co;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           busy;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [W:0]     exp_q[$];

    adder_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .flush       (flush),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_ci      (add_ci),
        .add_s       (add_s),
        .add_co      (add_co),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    // External 4-bit adder
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, sum}
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
        logic unused_sb;
        unused_sb = sb;
`ifdef ADDSEQ_SUB_EN
        if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
        return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    // One full transaction from the IDLE negedge; junk operands with
    // start_valid are driven while busy to prove they are never taken.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input int hold,
                          output logic [NIBBLES-1:0] cis, output logic [W:0] got);
        int n;
        logic [W:0] e;
        cis = '0;
        got = '0;
        check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        op_a = a; op_b = b; cin = ci; sub = sb; start_valid = 1'b1; res_ready = 1'b0;
        exp_q.push_back(model(a, b, ci, sb));
        @(negedge clk);
        op_a = ~a; op_b = ~b; cin = ~ci;
        n = 0;
        while (!res_valid && n < 40) begin
            if (n < NIBBLES) cis[n] = add_ci;
            if (start_ready) check({tag, "_ready_in_run"}, 64'(start_ready), 64'd0);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(NIBBLES));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < hold; i++) begin
                check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
                check({tag, "_hold_data"}, 64'({cout, sum}), 64'(e));
                check({tag, "_hold_ready"}, 64'(start_ready), 64'd0);
                @(negedge clk);
            end
            check({tag, "_result"}, 64'({cout, sum}), 64'(e));
        end
        got = {cout, sum};
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_back_idle"}, 64'({start_ready, res_valid, busy}), 64'b100);
    endtask

    initial begin
        logic [NIBBLES-1:0] cis;
        logic [W:0]         got;
        int                 last, cyc, accepted, done;
        logic [W-1:0]       ra, rb;
        logic               rc, rs;

        rst_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        sub = 1'b0; flush = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({start_ready, res_valid, busy, cout, add_ci}), 64'b10000);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_adder", 64'({add_a, add_b}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full carry ripple
        run_op("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, cis, got);
        check("t1_carry_chain", 64'(cis), 64'b1110);
        check("t1_lit", 64'(got), 64'h1_0000);

        // Carry-in and stalled consumer
        run_op("t2", 16'h1234, 16'h4321, 1'b1, 1'b0, 5, cis, got);
        check("t2_lit", 64'(got), 64'h0_5556);

        // Subtract request (honoured only when enabled)
        run_op("t5a", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, cis, got);
`ifdef ADDSEQ_SUB_EN
        check("t5a_lit", 64'(got), 64'h0_FFFE);
`else
        check("t5a_lit", 64'(got), 64'h0_000C);
`endif
        run_op("t5b", 16'h0007, 16'h0005, 1'b0, 1'b1, 0, cis, got);
`ifdef ADDSEQ_SUB_EN
        check("t5b_lit", 64'(got), 64'h1_0002);
`else
        check("t5b_lit", 64'(got), 64'h0_000C);
`endif

        // Flush beats start in IDLE
        op_a = 16'h1111; op_b = 16'h1111; start_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; flush = 1'b0;
        check("flush_vs_start", 64'({start_ready, busy}), 64'b10);

        // Flush at nibble 2 of a run
        op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("flush_at_k2_busy", 64'(busy), 64'd1);
        flush = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; start_valid = 1'b0;
        check("flush_idle", 64'({start_ready, res_valid, busy}), 64'b100);
        check("flush_partial", 64'(sum[7:0]), 64'h55);
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", 64'(res_valid), 64'd0);
            @(negedge clk);
        end
        run_op("t3", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, cis, got);
        check("t3_lit", 64'(got), 64'h0_0002);

        // Asynchronous reset mid-run
        op_a = 16'hABCD; op_b = 16'h1357; cin = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", 64'({start_ready, res_valid, busy, cout, add_ci}), 64'b10000);
        check("arst_sum", 64'(sum), 64'd0);
        check("arst_adder", 64'({add_a, add_b}), 64'd0);
        start_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("arst_after", 64'({start_ready, res_valid, busy}), 64'b100);
        check("arst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-to-back random operations with res_ready held high
        last = -1; cyc = 0; accepted = 0; done = 0;
        ra = W'($urandom); rb = W'($urandom); rc = 1'(($urandom)); rs = 1'($urandom);
        op_a = ra; op_b = rb; cin = rc; sub = rs;
        res_ready = 1'b1; start_valid = 1'b1;
        while (done < 1000 && cyc < 20000) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_queue", 64'd0, 64'd1);
                end else begin
                    check("b2b_result", 64'({cout, sum}), 64'(exp_q.pop_front()));
                end
                done++;
            end
            if (start_ready && start_valid) begin
                exp_q.push_back(model(ra, rb, rc, rs));
                if (last >= 0) check("b2b_spacing", 64'(cyc - last), 64'(NIBBLES + 2));
                last = cyc;
                accepted++;
                @(negedge clk);
                cyc++;
                if (accepted < 1000) begin
                    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                    op_a = ra; op_b = rb; cin = rc; sub = rs;
                end else begin
                    start_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b2b_done", 64'(done), 64'd1000);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
